csr_file: RTL and testbench

- Machine-mode CSR responder for the core; the other end of the CSR-access requests issued by the execute stage for SYSTEM (P_TYPE) instructions.
- Accepts one read-modify-write request at a time over a valid/ready handshake, returns the old value one cycle later, and flags illegal accesses.
- Also owns the free-running mcycle/minstret counters and the trap entry/return side-effects on mstatus/mepc/mcause/mtval.

---
 rtl/csr_file_pkg.sv | 53 +++++
 rtl/csr_file_counter64.sv | 31 +++
 rtl/csr_file.sv | 226 ++++++++++++++++++++++
 tb/tb_csr_file.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_file_pkg.sv
// Types, CSR address map and mstatus bit positions shared by the CSR file and its bench.
// The optional performance counters exist only when CSR_HPM_EN is defined.
package csr_file_pkg;

    typedef enum logic [1:0] {
        CSR_RW = 2'd0,
        CSR_RS = 2'd1,
        CSR_RC = 2'd2
    } csr_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } csr_state_t;

    typedef logic [11:0] csr_reg_t;

    localparam csr_reg_t CSR_MSTATUS   = 12'h300;
    localparam csr_reg_t CSR_MIE       = 12'h304;
    localparam csr_reg_t CSR_MTVEC     = 12'h305;
    localparam csr_reg_t CSR_MSCRATCH  = 12'h340;
    localparam csr_reg_t CSR_MEPC      = 12'h341;
    localparam csr_reg_t CSR_MCAUSE    = 12'h342;
    localparam csr_reg_t CSR_MTVAL     = 12'h343;
    localparam csr_reg_t CSR_MIP       = 12'h344;
    localparam csr_reg_t CSR_MCYCLE    = 12'hB00;
    localparam csr_reg_t CSR_MINSTRET  = 12'hB02;
    localparam csr_reg_t CSR_MCYCLEH   = 12'hB80;
    localparam csr_reg_t CSR_MINSTRETH = 12'hB82;
    localparam csr_reg_t CSR_CYCLE     = 12'hC00;
    localparam csr_reg_t CSR_INSTRET   = 12'hC02;
    localparam csr_reg_t CSR_CYCLEH    = 12'hC80;
    localparam csr_reg_t CSR_INSTRETH  = 12'hC82;
    localparam csr_reg_t CSR_MVENDORID = 12'hF11;
    localparam csr_reg_t CSR_MARCHID   = 12'hF12;
    localparam csr_reg_t CSR_MIMPID    = 12'hF13;
    localparam csr_reg_t CSR_MHARTID   = 12'hF14;

    localparam csr_reg_t CSR_MBRANCH_JUMP = 12'hB0B;
    localparam csr_reg_t CSR_MMIS_PREDICT = 12'hB0E;
    localparam csr_reg_t CSR_MSB_FULL     = 12'hB0F;
    localparam csr_reg_t CSR_BRANCH_JUMP  = 12'hC0B;
    localparam csr_reg_t CSR_MIS_PREDICT  = 12'hC0E;
    localparam csr_reg_t CSR_SB_FULL      = 12'hC0F;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    function automatic logic csr_is_read_only(input csr_reg_t addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit event counter with separate low/high write ports; a write to either
// half replaces the increment for the whole counter in that cycle.
module csr_counter64 #(
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INC_W-1:0] i_inc,
    input  logic             i_wr_lo,
    input  logic             i_wr_hi,
    input  logic [31:0]      i_wdata,
    output logic [63:0]      o_cnt
);

    logic [63:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_wr_lo) begin
            r_cnt <= {r_cnt[63:32], i_wdata};
        end else if (i_wr_hi) begin
            r_cnt <= {i_wdata, r_cnt[31:0]};
        end else begin
            r_cnt <= r_cnt + 64'(i_inc);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR responder: one read-modify-write per handshake, counters and trap side-effects.
// Define CSR_HPM_EN to add the branch / mispredict / scoreboard-full event counters.
module csr_file
    import csr_file_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              RETIRE_W    = 2,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [11:0]                     req_addr_i,
    input  csr_op_t                         req_op_i,
    input  logic                            req_we_i,
    input  logic [XLEN-1:0]                 req_wdata_i,
    output logic                            resp_valid_o,
    input  logic                            resp_ready_i,
    output logic [XLEN-1:0]                 resp_rdata_o,
    output logic                            resp_illegal_o,
    input  logic [$clog2(RETIRE_W+1)-1:0]   retire_cnt_i,
`ifdef CSR_HPM_EN
    input  logic                            ev_branch_i,
    input  logic                            ev_mispredict_i,
    input  logic                            ev_sb_full_i,
`endif
    input  logic                            trap_valid_i,
    input  logic [XLEN-1:0]                 trap_pc_i,
    input  logic [XLEN-1:0]                 trap_cause_i,
    input  logic [XLEN-1:0]                 trap_tval_i,
    input  logic                            mret_i,
    output logic [XLEN-1:0]                 mtvec_o,
    output logic [XLEN-1:0]                 mepc_o
);

    localparam int              RC_W       = $clog2(RETIRE_W + 1);
    localparam logic [XLEN-1:0] MTVEC_MASK = ~(XLEN'(3));
    localparam logic [XLEN-1:0] MEPC_MASK  = ~(XLEN'(1));

    csr_state_t      r_state;
    logic            r_req_ready;
    logic            r_resp_valid;
    logic            r_resp_illegal;
    logic [XLEN-1:0] r_resp_rdata;

    logic            r_mstatus_mie;
    logic            r_mstatus_mpie;
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;

    logic [63:0]     w_mcycle;
    logic [63:0]     w_minstret;
    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_new;
    logic            w_known;
    logic            w_illegal;
    logic            w_accept;
    logic            w_wr;
    logic            w_sys_evt;

`ifdef CSR_HPM_EN
    logic [31:0]     r_hpm_branch;
    logic [31:0]     r_hpm_mispredict;
    logic [31:0]     r_hpm_sb_full;
`endif

    always_comb begin
        w_mstatus                   = '0;
        w_mstatus[MSTATUS_MIE_BIT]  = r_mstatus_mie;
        w_mstatus[MSTATUS_MPIE_BIT] = r_mstatus_mpie;
        w_old                       = '0;
        w_known                     = 1'b1;
        case (req_addr_i)
            CSR_MSTATUS:                    w_old = w_mstatus;
            CSR_MIE:                        w_old = r_mie;
            CSR_MTVEC:                      w_old = r_mtvec;
            CSR_MSCRATCH:                   w_old = r_mscratch;
            CSR_MEPC:                       w_old = r_mepc;
            CSR_MCAUSE:                     w_old = r_mcause;
            CSR_MTVAL:                      w_old = r_mtval;
            CSR_MIP, CSR_MVENDORID, CSR_MARCHID,
            CSR_MIMPID, CSR_MHARTID:        w_old = '0;
            CSR_MCYCLE, CSR_CYCLE:          w_old = XLEN'(w_mcycle[31:0]);
            CSR_MCYCLEH, CSR_CYCLEH:        w_old = XLEN'(w_mcycle[63:32]);
            CSR_MINSTRET, CSR_INSTRET:      w_old = XLEN'(w_minstret[31:0]);
            CSR_MINSTRETH, CSR_INSTRETH:    w_old = XLEN'(w_minstret[63:32]);
`ifdef CSR_HPM_EN
            CSR_MBRANCH_JUMP, CSR_BRANCH_JUMP: w_old = XLEN'(r_hpm_branch);
            CSR_MMIS_PREDICT, CSR_MIS_PREDICT: w_old = XLEN'(r_hpm_mispredict);
            CSR_MSB_FULL, CSR_SB_FULL:         w_old = XLEN'(r_hpm_sb_full);
`endif
            default:                        w_known = 1'b0;
        endcase
    end

    always_comb begin
        case (req_op_i)
            CSR_RW:  w_new = req_wdata_i;
            CSR_RS:  w_new = w_old | req_wdata_i;
            CSR_RC:  w_new = w_old & ~req_wdata_i;
            default: w_new = w_old;
        endcase
    end

    assign w_illegal = !w_known || (req_we_i && csr_is_read_only(req_addr_i));
    assign w_accept  = req_valid_i && r_req_ready;
    assign w_wr      = w_accept && req_we_i && !w_illegal;
    assign w_sys_evt = trap_valid_i || mret_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_illegal <= 1'b0;
            r_resp_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state        <= ST_RESP;
                        r_req_ready    <= 1'b0;
                        r_resp_valid   <= 1'b1;
                        r_resp_illegal <= w_illegal;
                        r_resp_rdata   <= w_illegal ? '0 : w_old;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        r_state      <= ST_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Trap entry and mret own the trap-state CSRs in the cycle they fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RESET & MTVEC_MASK;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
        end else begin
            if (trap_valid_i) begin
                r_mepc         <= trap_pc_i & MEPC_MASK;
                r_mcause       <= trap_cause_i;
                r_mtval        <= trap_tval_i;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (mret_i) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_wr && !w_sys_evt) begin
                if (req_addr_i == CSR_MSTATUS) begin
                    r_mstatus_mie  <= w_new[MSTATUS_MIE_BIT];
                    r_mstatus_mpie <= w_new[MSTATUS_MPIE_BIT];
                end
                if (req_addr_i == CSR_MEPC)   r_mepc   <= w_new & MEPC_MASK;
                if (req_addr_i == CSR_MCAUSE) r_mcause <= w_new;
                if (req_addr_i == CSR_MTVAL)  r_mtval  <= w_new;
            end
            if (w_wr && req_addr_i == CSR_MIE)      r_mie      <= w_new;
            if (w_wr && req_addr_i == CSR_MTVEC)    r_mtvec    <= w_new & MTVEC_MASK;
            if (w_wr && req_addr_i == CSR_MSCRATCH) r_mscratch <= w_new;
        end
    end

    csr_counter64 #(.INC_W(1)) u_mcycle (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (1'b1),
        .i_wr_lo (w_wr && req_addr_i == CSR_MCYCLE),
        .i_wr_hi (w_wr && req_addr_i == CSR_MCYCLEH),
        .i_wdata (w_new[31:0]),
        .o_cnt   (w_mcycle)
    );

    csr_counter64 #(.INC_W(RC_W)) u_minstret (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (retire_cnt_i),
        .i_wr_lo (w_wr && req_addr_i == CSR_MINSTRET),
        .i_wr_hi (w_wr && req_addr_i == CSR_MINSTRETH),
        .i_wdata (w_new[31:0]),
        .o_cnt   (w_minstret)
    );

`ifdef CSR_HPM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hpm_branch     <= '0;
            r_hpm_mispredict <= '0;
            r_hpm_sb_full    <= '0;
        end else begin
            if (w_wr && req_addr_i == CSR_MBRANCH_JUMP) r_hpm_branch <= w_new[31:0];
            else if (ev_branch_i)                       r_hpm_branch <= r_hpm_branch + 32'd1;
            if (w_wr && req_addr_i == CSR_MMIS_PREDICT) r_hpm_mispredict <= w_new[31:0];
            else if (ev_mispredict_i)                   r_hpm_mispredict <= r_hpm_mispredict + 32'd1;
            if (w_wr && req_addr_i == CSR_MSB_FULL)     r_hpm_sb_full <= w_new[31:0];
            else if (ev_sb_full_i)                      r_hpm_sb_full <= r_hpm_sb_full + 32'd1;
        end
    end
`endif

    assign req_ready_o    = r_req_ready;
    assign resp_valid_o   = r_resp_valid;
    assign resp_rdata_o   = r_resp_rdata;
    assign resp_illegal_o = r_resp_illegal;
    assign mtvec_o        = r_mtvec;
    assign mepc_o         = r_mepc;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed CSR scenarios plus random traffic against a behavioural model and response scoreboard.
`timescale 1ns/1ps
module tb_csr_file;
    import csr_file_pkg::*;

    localparam int          XLEN      = 32;
    localparam int          RETIRE_W  = 2;
    localparam int          RC_W      = $clog2(RETIRE_W + 1);
    localparam logic [31:0] MTVEC_RST = 32'h0000_1000;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [11:0]     req_addr_i;
    csr_op_t         req_op_i;
    logic            req_we_i;
    logic [31:0]     req_wdata_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [31:0]     resp_rdata_o;
    logic            resp_illegal_o;
    logic [RC_W-1:0] retire_cnt_i;
    logic            trap_valid_i;
    logic [31:0]     trap_pc_i;
    logic [31:0]     trap_cause_i;
    logic [31:0]     trap_tval_i;
    logic            mret_i;
    logic [31:0]     mtvec_o;
    logic [31:0]     mepc_o;

    always #5 clk = ~clk;

    csr_file #(.XLEN(XLEN), .RETIRE_W(RETIRE_W), .MTVEC_RESET(MTVEC_RST)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_op_i       (req_op_i),
        .req_we_i       (req_we_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_rdata_o   (resp_rdata_o),
        .resp_illegal_o (resp_illegal_o),
        .retire_cnt_i   (retire_cnt_i),
`ifdef CSR_HPM_EN
        .ev_branch_i    (1'b0),
        .ev_mispredict_i(1'b0),
        .ev_sb_full_i   (1'b0),
`endif
        .trap_valid_i   (trap_valid_i),
        .trap_pc_i      (trap_pc_i),
        .trap_cause_i   (trap_cause_i),
        .trap_tval_i    (trap_tval_i),
        .mret_i         (mret_i),
        .mtvec_o        (mtvec_o),
        .mepc_o         (mepc_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] rdata;
        logic        illegal;
    } exp_t;

    exp_t        exp_q[$];
    logic        m_busy;
    logic        m_mie_b, m_mpie_b;
    logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ins;
    logic [31:0] m_hpm [3];

    function automatic logic [32:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, 24'h0, m_mpie_b, 3'b000, m_mie_b, 3'b000};
            12'h304: return {1'b1, m_mie};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
            12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14: return {1'b1, 32'h0};
            12'hB00, 12'hC00: return {1'b1, m_cyc[31:0]};
            12'hB80, 12'hC80: return {1'b1, m_cyc[63:32]};
            12'hB02, 12'hC02: return {1'b1, m_ins[31:0]};
            12'hB82, 12'hC82: return {1'b1, m_ins[63:32]};
`ifdef CSR_HPM_EN
            12'hB0B, 12'hC0B: return {1'b1, m_hpm[0]};
            12'hB0E, 12'hC0E: return {1'b1, m_hpm[1]};
            12'hB0F, 12'hC0F: return {1'b1, m_hpm[2]};
`endif
            default: return 33'h0;
        endcase
    endfunction

    logic [32:0] md_rd;
    logic [31:0] md_nv;
    logic        md_ill;
    logic [63:0] md_cyc, md_ins;
    exp_t        md_e;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_busy = 1'b0; m_mie_b = 1'b0; m_mpie_b = 1'b0;
            m_mie = '0; m_mtvec = MTVEC_RST; m_mscratch = '0;
            m_mepc = '0; m_mcause = '0; m_mtval = '0;
            m_cyc = '0; m_ins = '0;
            for (int k = 0; k < 3; k++) m_hpm[k] = '0;
        end else begin
            md_cyc = m_cyc + 64'd1;
            md_ins = m_ins + 64'(retire_cnt_i);
            if (req_valid_i && !m_busy) begin
                md_rd  = m_read(req_addr_i);
                md_ill = !md_rd[32] || (req_we_i && req_addr_i[11:10] == 2'b11);
                md_e.rdata   = md_ill ? 32'h0 : md_rd[31:0];
                md_e.illegal = md_ill;
                exp_q.push_back(md_e);
                case (req_op_i)
                    CSR_RW:  md_nv = req_wdata_i;
                    CSR_RS:  md_nv = md_rd[31:0] | req_wdata_i;
                    default: md_nv = md_rd[31:0] & ~req_wdata_i;
                endcase
                if (req_we_i && !md_ill) begin
                    case (req_addr_i)
                        12'h300: if (!trap_valid_i && !mret_i) begin
                                     m_mie_b = md_nv[3]; m_mpie_b = md_nv[7];
                                 end
                        12'h304: m_mie = md_nv;
                        12'h305: m_mtvec = {md_nv[31:2], 2'b00};
                        12'h340: m_mscratch = md_nv;
                        12'h341: if (!trap_valid_i && !mret_i) m_mepc = {md_nv[31:1], 1'b0};
                        12'h342: if (!trap_valid_i && !mret_i) m_mcause = md_nv;
                        12'h343: if (!trap_valid_i && !mret_i) m_mtval = md_nv;
                        12'hB00: md_cyc = {m_cyc[63:32], md_nv};
                        12'hB80: md_cyc = {md_nv, m_cyc[31:0]};
                        12'hB02: md_ins = {m_ins[63:32], md_nv};
                        12'hB82: md_ins = {md_nv, m_ins[31:0]};
                        12'hB0B: m_hpm[0] = md_nv;
                        12'hB0E: m_hpm[1] = md_nv;
                        12'hB0F: m_hpm[2] = md_nv;
                        default: ;
                    endcase
                end
                m_busy = 1'b1;
            end else if (m_busy && resp_ready_i) begin
                m_busy = 1'b0;
            end
            if (trap_valid_i) begin
                m_mepc = {trap_pc_i[31:1], 1'b0};
                m_mcause = trap_cause_i;
                m_mtval = trap_tval_i;
                m_mpie_b = m_mie_b;
                m_mie_b = 1'b0;
            end else if (mret_i) begin
                m_mie_b = m_mpie_b;
                m_mpie_b = 1'b1;
            end
            m_cyc = md_cyc;
            m_ins = md_ins;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            chk("req_ready", 32'(req_ready_o), 32'(!m_busy));
            chk("resp_valid", 32'(resp_valid_o), 32'(m_busy));
            chk("mtvec_o", mtvec_o, m_mtvec);
            chk("mepc_o", mepc_o, m_mepc);
            if (resp_valid_o && resp_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 32'(resp_valid_o), 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata_o, mon_e.rdata);
                    chk("resp_illegal", 32'(resp_illegal_o), 32'(mon_e.illegal));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [11:0] a, input csr_op_t op, input logic we, input logic [31:0] wd);
        int n = 0;
        req_valid_i = 1'b1; req_addr_i = a; req_op_i = op; req_we_i = we; req_wdata_i = wd;
        while (!req_ready_o && n <= 60) begin
            @(posedge clk); #2;
            n++;
        end
        if (n > 60) chk("accept_timeout", 32'(n), 32'd60);
        @(posedge clk); #2;
        req_valid_i = 1'b0;
    endtask

    task automatic read_csr(input logic [11:0] a, output logic [31:0] v, output logic ill);
        issue(a, CSR_RS, 1'b0, 32'h0);
        v = resp_rdata_o;
        ill = resp_illegal_o;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready_o && n <= 60) begin
            @(posedge clk); #2;
            n++;
        end
        if (n > 60) chk("idle_timeout", 32'(n), 32'd60);
    endtask

    logic rnd_en = 1'b0;
    always @(posedge clk) begin
        if (rnd_en) begin
            #2;
            resp_ready_i = ($urandom_range(0, 3) != 0);
            retire_cnt_i = RC_W'($urandom_range(0, RETIRE_W));
            trap_valid_i = ($urandom_range(0, 15) == 0);
            mret_i       = ($urandom_range(0, 15) == 0);
            trap_pc_i    = $urandom;
            trap_cause_i = $urandom;
            trap_tval_i  = $urandom;
        end
    end

    logic [11:0] addr_pool [22] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                                    12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'hF11, 12'hF14,
                                    12'h7FF, 12'hB0B, 12'hC0F, 12'h301};

    logic [31:0] v, v0, held;
    logic        ill;

    initial begin
        reset = 1'b1;
        req_valid_i = 1'b0; req_addr_i = '0; req_op_i = CSR_RW; req_we_i = 1'b0; req_wdata_i = '0;
        resp_ready_i = 1'b1; retire_cnt_i = '0;
        trap_valid_i = 1'b0; trap_pc_i = '0; trap_cause_i = '0; trap_tval_i = '0; mret_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_resp_valid", 32'(resp_valid_o), 32'h0);
        chk("rst_resp_rdata", resp_rdata_o, 32'h0);
        chk("rst_resp_illegal", 32'(resp_illegal_o), 32'h0);
        chk("rst_req_ready", 32'(req_ready_o), 32'h1);
        chk("rst_mtvec", mtvec_o, MTVEC_RST);
        chk("rst_mepc", mepc_o, 32'h0);
        reset = 1'b0;
        @(posedge clk); #2;

        issue(12'h340, CSR_RW, 1'b1, 32'hDEADBEEF);
        chk("latency_valid", 32'(resp_valid_o), 32'h1);
        read_csr(12'h340, v, ill);
        chk("mscratch_rw", v, 32'hDEADBEEF);
        chk("mscratch_rw_ill", 32'(ill), 32'h0);

        issue(12'h340, CSR_RW, 1'b1, 32'hF0F0F0F0);
        read_csr(12'h340, v, ill);
        issue(12'h340, CSR_RC, 1'b1, 32'h000000FF);
        chk("rc_old", resp_rdata_o, 32'hF0F0F0F0);
        read_csr(12'h340, v, ill);
        chk("rc_new", v, 32'hF0F0F000);

        issue(12'hF11, CSR_RW, 1'b1, 32'h1);
        chk("ro_write_ill", 32'(resp_illegal_o), 32'h1);
        chk("ro_write_rdata", resp_rdata_o, 32'h0);
        read_csr(12'h7FF, v, ill);
        chk("unknown_ill", 32'(ill), 32'h1);

        issue(12'hB80, CSR_RW, 1'b1, 32'h0);
        issue(12'hB00, CSR_RW, 1'b1, 32'hFFFFFFFF);
        read_csr(12'hB80, v, ill);
        chk("mcycleh_carry", v, 32'h1);

        read_csr(12'hB02, v0, ill);
        retire_cnt_i = RC_W'(2);
        repeat (5) @(posedge clk);
        #2;
        retire_cnt_i = '0;
        read_csr(12'hB02, v, ill);
        chk("minstret_plus10", v - v0, 32'd10);

        issue(12'h300, CSR_RW, 1'b1, 32'h8);
        wait_idle();
        trap_valid_i = 1'b1; trap_pc_i = 32'h100; trap_cause_i = 32'd2; trap_tval_i = 32'h13;
        @(posedge clk); #2;
        trap_valid_i = 1'b0;
        chk("trap_mepc", mepc_o, 32'h100);
        read_csr(12'h342, v, ill);
        chk("trap_mcause", v, 32'd2);
        read_csr(12'h343, v, ill);
        chk("trap_mtval", v, 32'h13);
        read_csr(12'h300, v, ill);
        chk("trap_mstatus", v, 32'h80);
        wait_idle();
        mret_i = 1'b1;
        @(posedge clk); #2;
        mret_i = 1'b0;
        read_csr(12'h300, v, ill);
        chk("mret_mstatus", v, 32'h88);

        // trap in the same cycle as an mepc write: the trap value must stick
        wait_idle();
        req_valid_i = 1'b1; req_addr_i = 12'h341; req_op_i = CSR_RW; req_we_i = 1'b1; req_wdata_i = 32'h4444;
        trap_valid_i = 1'b1; trap_pc_i = 32'h200;
        @(posedge clk); #2;
        req_valid_i = 1'b0; trap_valid_i = 1'b0;
        chk("trap_beats_write_old", resp_rdata_o, 32'h100);
        chk("trap_beats_write", mepc_o, 32'h200);

        wait_idle();
        resp_ready_i = 1'b0;
        issue(12'h340, CSR_RS, 1'b0, 32'h0);
        held = resp_rdata_o;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid_o), 32'h1);
            chk("hold_rdata", resp_rdata_o, held);
            chk("hold_ready", 32'(req_ready_o), 32'h0);
        end
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(resp_valid_o), 32'h0);
        chk("rst_mid_ready", 32'(req_ready_o), 32'h1);
        @(posedge clk); #2;
        reset = 1'b0;
        resp_ready_i = 1'b1;
        read_csr(12'h340, v, ill);
        chk("rst_mscratch", v, 32'h0);

        rnd_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            issue(addr_pool[$urandom_range(0, 21)], csr_op_t'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), $urandom);
        end
        rnd_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        resp_ready_i = 1'b1; retire_cnt_i = '0; trap_valid_i = 1'b0; mret_i = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
